// File: rtl/vga_scan.sv
// VGA display scan controller: raster counters, downscaled frame-buffer read
// coordinates, and sync/DE/colour pins aligned to the buffer read latency.
package vga_scan_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_color_t;
endpackage

module vga_scan
  import vga_scan_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_pxlX,
  output logic [7:0] o_pxlY,
  input  vga_color_t i_color,
  output vga_color_t o_color,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic       o_frameStart,
  output logic       o_vblank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_ON  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_OFF = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_ON  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_OFF = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0]      h_cnt_q, h_cnt_d;
  logic [V_W-1:0]      v_cnt_q, v_cnt_d;
  logic [READ_LAT-1:0] de_pipe_q, de_pipe_d;
  logic [READ_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [READ_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic                de_q, de_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  vga_color_t          color_q, color_d;
  logic                vblank_q, vblank_d;
  logic                wrap_q, wrap_d;
  logic                frame_start_q, frame_start_d;

  logic active_c;
  logic hs_c;
  logic vs_c;

  // Raster counters: h wraps every line, v steps on each h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + H_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
    end
  end

  // Counter-stage decode of visibility and sync windows.
  always_comb begin
    active_c = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_c     = !((h_cnt_q >= H_SYNC_ON) && (h_cnt_q < H_SYNC_OFF));
    vs_c     = !((v_cnt_q >= V_SYNC_ON) && (v_cnt_q < V_SYNC_OFF));
  end

  assign o_pxlX = active_c ? 8'(h_cnt_q >> SCALE_SHIFT) : 8'd0;
  assign o_pxlY = active_c ? 8'(v_cnt_q >> SCALE_SHIFT) : 8'd0;

  // Delay line matching the frame-buffer read latency.
  always_comb begin
    de_pipe_d    = de_pipe_q;
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    de_pipe_d[0] = active_c;
    hs_pipe_d[0] = hs_c;
    vs_pipe_d[0] = vs_c;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      de_pipe_d[i] = de_pipe_q[i-1];
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end
  end

  // Pin stage: colour only passes when the aligned pixel is visible.
  always_comb begin
    de_d          = de_pipe_q[READ_LAT-1];
    hsync_d       = hs_pipe_q[READ_LAT-1];
    vsync_d       = vs_pipe_q[READ_LAT-1];
    color_d       = de_pipe_q[READ_LAT-1] ? i_color : '0;
    vblank_d      = (v_cnt_q >= V_VIS);
    wrap_d        = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    frame_start_d = wrap_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      de_pipe_q     <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      de_q          <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      color_q       <= '0;
      vblank_q      <= 1'b0;
      wrap_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      de_pipe_q     <= de_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      color_q       <= color_d;
      vblank_q      <= vblank_d;
      wrap_q        <= wrap_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_de         = de_q;
  assign o_hsync      = hsync_q;
  assign o_vsync      = vsync_q;
  assign o_color      = color_q;
  assign o_vblank     = vblank_q;
  assign o_frameStart = frame_start_q;

endmodule

// File: doc/vga_scan.md
Name: vga_scan

Overview:
Display-side scan controller for the VGA frame buffer.
- Generates the horizontal and vertical raster timing.
- Drives the frame-buffer read coordinates (pxlX/pxlY), downscaled from screen pixels.
- Takes the colour the buffer returns after a fixed read latency and aligns it with the delayed sync and data-enable signals.
- Produces registered hsync/vsync/RGB for the pins, plus frame-start and vblank status for the CPU side.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SCALE_SHIFT, 2, screen-to-buffer downscale as log2; H_ACTIVE>>SCALE_SHIFT and V_ACTIVE>>SCALE_SHIFT must each be ≤256
READ_LAT, 1, frame-buffer read latency in cycles (≥1)

Ports:
i_clk  input  1  pixel clock (only clock)
i_rst  input  1  synchronous, active-high reset
o_pxlX  output  8  frame-buffer read X
o_pxlY  output  8  frame-buffer read Y
i_color  input  vga_color_t  colour returned by frame buffer, READ_LAT cycles after o_pxlX/o_pxlY
o_color  output  vga_color_t  pin colour, zero while blanking
o_hsync  output  1  horizontal sync, active low
o_vsync  output  1  vertical sync, active low
o_de  output  1  data enable, high on visible pixels
o_frameStart  output  1  one-cycle pulse at start of each frame
o_vblank  output  1  high while v_cnt ≥ V_ACTIVE

Behaviour:
Interface:
- One clock, i_clk. Reset i_rst is synchronous and active-high.

Reset:
- h_cnt=0, v_cnt=0.
- All delay pipelines cleared: de=0, hsync=1, vsync=1.
- Outputs: o_pxlX=0, o_pxlY=0, o_color=0, o_hsync=1, o_vsync=1, o_de=0, o_frameStart=0, o_vblank=0.
- Reset asserted mid-frame: same values on the next edge. Any in-flight pipeline contents are discarded.

Counters:
- Cycle 0 is the first cycle with i_rst low; h_cnt=0 during cycle 0.
- h_cnt increments every cycle. It wraps from H_TOTAL-1 to 0.
- On that wrap, v_cnt increments, wrapping from V_TOTAL-1 to 0.

Stage 0 (combinational from counters):
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs = !(H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC).
- vs = !(V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC).

Read coordinates:
- o_pxlX = active ? (h_cnt>>SCALE_SHIFT)[7:0] : 0, driven from the counter stage with no extra register.
- o_pxlY = active ? (v_cnt>>SCALE_SHIFT)[7:0] : 0, likewise.

Pipeline alignment:
- active, hs and vs pass through a READ_LAT-deep shift register.
- Output registers capture:
  - o_de ← active delayed;
  - o_hsync ← hs delayed;
  - o_vsync ← vs delayed;
  - o_color ← (active delayed) ? i_color : 0.
- Pin latency is READ_LAT+1 cycles from the counter value, for all four outputs alike.
- i_color is ignored whenever the delayed active bit is 0.

Status (counter stage):
- o_vblank = (v_cnt ≥ V_ACTIVE), registered, so it lags v_cnt by 1 cycle.
- o_frameStart pulses high for exactly 1 cycle, the cycle after the counters step from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- No o_frameStart pulse is produced on reset release.

Boundaries:
- Last visible pixel (639,479) maps to (159,119) at default settings.
- Vsync edges coincide with the start of an hsync line boundary (h_cnt=0), both delayed identically.
- No run-time parameter changes are supported.

Test Plan:
1. Reset, then release at cycle 0 → during reset all outputs at their reset values. o_de first high at cycle 2, o_color = i_color sampled at cycle 1.
2. Free-run one line → o_hsync low for cycles 658..753 (96 cycles). Next fall at 1458, giving an 800-cycle period. o_de high for 640 consecutive cycles per visible line.
3. Free-run one frame → o_vsync low from cycle 490*800+2 for 1600 cycles. o_vblank rises at cycle 480*800+1. o_frameStart pulses at cycle 420001. Next pulse is 420000 cycles later.
4. Frame-buffer model returning {x,y,x^y} with 1-cycle latency, h_cnt=5, v_cnt=9 → o_pxlX=1, o_pxlY=2 at that cycle. Pins show colour {1,2,3} two cycles later.
5. Blanking check: i_color forced to all-ones throughout → o_color=0 whenever o_de=0 (e.g. h_cnt 640..799, v_cnt ≥480). o_pxlX and o_pxlY are 0 during blanking.
6. Assert i_rst for 1 cycle at h_cnt=300, v_cnt=200 → the next cycle shows reset values (o_hsync=1, o_de=0, o_color=0). The counter restarts at 0 and the hsync fall recurs 658 cycles after release.
